// File: rtl/inst_inject_trace.sv
// Instruction injection / single-step front end for a processor decoder, with a
// circular trace buffer that records {wrt_en, pc_in, wrt_val} on every committed cycle.
module inst_inject_trace #(
  parameter int                        DBITS          = 32,
  parameter int                        INST_BIT_WIDTH = 32,
  parameter int                        INJ_DEPTH      = 8,
  parameter int                        TRACE_DEPTH    = 16,
  parameter logic [INST_BIT_WIDTH-1:0] NOP_WORD       = 32'h80000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic                           step,
  input  logic                           inj_valid,
  input  logic [INST_BIT_WIDTH-1:0]      inj_word,
  output logic                           inj_ready,
  input  logic [INST_BIT_WIDTH-1:0]      imem_word,
  output logic [INST_BIT_WIDTH-1:0]      inst_out,
  output logic                           stall,
  input  logic [DBITS-1:0]               pc_in,
  input  logic                           wrt_en,
  input  logic [DBITS-1:0]               wrt_val,
  input  logic                           trace_rd_en,
  output logic [2*DBITS:0]               trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);

  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int TAW = $clog2(TRACE_DEPTH);
  localparam int TW  = 2 * DBITS + 1;
  localparam logic [TAW:0] TRACE_FULL = (TAW + 1)'(TRACE_DEPTH);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INJECT = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;

  typedef enum logic [2:0] {
    S_PASS,
    S_INJ,
    S_STEP_IDLE,
    S_STEP_ARM,
    S_HALT
  } stateT;

  stateT stateQ, stateNext;

  // Injection FIFO: pointers carry one extra bit to tell full from empty.
  logic [INST_BIT_WIDTH-1:0] injMem [INJ_DEPTH];
  logic [IAW:0]              injWr, injRd;
  logic                      injEmpty, injFull, injPush, injPop;

  logic [TW-1:0]  trMem [TRACE_DEPTH];
  logic [TAW-1:0] trWr, trRd;
  logic [TAW:0]   trCount;
  logic           trFull, trRdValid, trOverwrite;

  logic commit;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) stateQ <= S_PASS;
    else       stateQ <= stateNext;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
    stateNext = S_HALT;
    case (mode)
      MODE_PASS:   stateNext = S_PASS;
      MODE_INJECT: stateNext = S_INJ;
      MODE_STEP: begin
        // A step only arms from idle; a step seen while armed is dropped.
        if (stateQ == S_STEP_IDLE && step) stateNext = S_STEP_ARM;
        else                               stateNext = S_STEP_IDLE;
      end
      default:     stateNext = S_HALT;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    inst_out = NOP_WORD;
    stall    = 1'b1;
    commit   = 1'b0;
    if (!reset) begin
      case (stateQ)
        S_PASS: begin
          inst_out = imem_word;
          stall    = 1'b0;
          commit   = 1'b1;
        end
        S_INJ, S_STEP_ARM: begin
          if (!injEmpty) begin
            inst_out = injMem[injRd[IAW-1:0]];
            stall    = 1'b0;
            commit   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- injection FIFO ----------------
  assign injEmpty  = (injWr == injRd);
  assign injFull   = (injWr[IAW] != injRd[IAW]) && (injWr[IAW-1:0] == injRd[IAW-1:0]);
  assign inj_ready = !injFull;
  assign injPush   = inj_valid && !injFull && !reset;
  assign injPop    = commit && (stateQ != S_PASS);

  always_ff @(posedge clk) begin
    if (reset) begin
      injWr <= '0;
      injRd <= '0;
    end else begin
      if (injPush) injWr <= injWr + 1'b1;
      if (injPop)  injRd <= injRd + 1'b1;
    end
  end

  // NOTE: storage arrays are not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (injPush) injMem[injWr[IAW-1:0]] <= inj_word;
  end

  // ---------------- trace buffer ----------------
  assign trFull      = (trCount == TRACE_FULL);
  assign trRdValid   = trace_rd_en && (trCount != '0);
  // A same-cycle read frees the slot, so only an unread full buffer overwrites.
  assign trOverwrite = commit && trFull && !trRdValid;
  assign trace_count = trCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      trWr           <= '0;
      trRd           <= '0;
      trCount        <= '0;
      trace_overflow <= 1'b0;
      trace_rd_data  <= '0;
    end else begin
      if (commit) trWr <= trWr + 1'b1;
      if (trRdValid) begin
        trace_rd_data <= trMem[trRd];
        trRd          <= trRd + 1'b1;
      end else if (trOverwrite) begin
        trRd           <= trRd + 1'b1;
        trace_overflow <= 1'b1;
      end
      if (commit && !trRdValid && !trFull) trCount <= trCount + 1'b1;
      else if (!commit && trRdValid)       trCount <= trCount - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) trMem[trWr] <= {wrt_en, pc_in, wrt_val};
  end

endmodule

// File: tb/tb_inst_inject_trace.sv
// Directed bench for inst_inject_trace: a queue-based model checked every cycle,
// plus literal expectations for the reset, inject, step, overflow and reset-in-step cases.
module tb_inst_inject_trace;

  localparam int DBITS       = 32;
  localparam int IW          = 32;
  localparam int INJ_DEPTH   = 8;
  localparam int TRACE_DEPTH = 16;
  localparam logic [IW-1:0] NOP = 32'h80000000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic             step = 1'b0;
  logic             injValid = 1'b0;
  logic [IW-1:0]    injWord = '0;
  logic             injReady;
  logic [IW-1:0]    imemWord = 32'h1000_0100;
  logic [IW-1:0]    instOut;
  logic             stall;
  logic [DBITS-1:0] pcIn = 32'h100;
  logic             wrtEn = 1'b0;
  logic [DBITS-1:0] wrtVal = 32'hA5A5_0100;
  logic             traceRdEn = 1'b0;
  logic [2*DBITS:0] traceRdData;
  logic [4:0]       traceCount;
  logic             traceOverflow;

  int nCompared = 0;
  int nMismatched = 0;

  inst_inject_trace #(
    .DBITS(DBITS), .INST_BIT_WIDTH(IW), .INJ_DEPTH(INJ_DEPTH),
    .TRACE_DEPTH(TRACE_DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .step(step),
    .inj_valid(injValid), .inj_word(injWord), .inj_ready(injReady),
    .imem_word(imemWord), .inst_out(instOut), .stall(stall),
    .pc_in(pcIn), .wrt_en(wrtEn), .wrt_val(wrtVal),
    .trace_rd_en(traceRdEn), .trace_rd_data(traceRdData),
    .trace_count(traceCount), .trace_overflow(traceOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [64:0] act, logic [64:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Free-running commit-side bus: new pc / write data / imem word every cycle.
  initial begin
    logic [31:0] pcReg;
    pcReg = 32'h100;
    forever begin
      @(posedge clk);
      #1;
      pcReg    = pcReg + 32'd4;
      pcIn     = pcReg;
      wrtVal   = pcReg ^ 32'hA5A5_0000;
      wrtEn    = pcReg[2];
      imemWord = 32'h1000_0000 | pcReg;
    end
  end

  // ---------------- behavioural model ----------------
  logic [IW-1:0]    mFifo[$];
  logic [2*DBITS:0] mTrace[$];
  logic [2*DBITS:0] mRdData;
  int  mMode;
  bit  mArmed, mOverflow, started;
  bit  mCommit, mPush, mRd;

  always @(posedge clk) begin
    if (reset) begin
      mMode = 0;
      mArmed = 1'b0;
      mFifo.delete();
      mTrace.delete();
      mOverflow = 1'b0;
      mRdData = '0;
      started = 1'b1;
    end else begin
      mCommit = (mMode == 0) ||
                ((mMode == 1 || (mMode == 2 && mArmed)) && mFifo.size() > 0);
      mPush   = injValid && (mFifo.size() < INJ_DEPTH);
      mRd     = traceRdEn && (mTrace.size() > 0);
      if (mRd) mRdData = mTrace.pop_front();
      if (mCommit) begin
        if (mTrace.size() == TRACE_DEPTH) begin
          void'(mTrace.pop_front());
          mOverflow = 1'b1;
        end
        mTrace.push_back({wrtEn, pcIn, wrtVal});
      end
      if (mCommit && mMode != 0) void'(mFifo.pop_front());
      if (mPush) mFifo.push_back(injWord);
      mArmed = (mode == 2'd2) && (mMode == 2) && !mArmed && step;
      mMode  = int'(mode);
    end
  end

  logic [IW-1:0] eInst;
  logic          eStall;

  always @(negedge clk) begin
    if (started) begin
      eInst  = NOP;
      eStall = 1'b1;
      if (!reset) begin
        if (mMode == 0) begin
          eInst  = imemWord;
          eStall = 1'b0;
        end else if ((mMode == 1 || (mMode == 2 && mArmed)) && mFifo.size() > 0) begin
          eInst  = mFifo[0];
          eStall = 1'b0;
        end
      end
      check("cyc_inst_out", instOut, eInst);
      check("cyc_stall", stall, eStall);
      check("cyc_inj_ready", injReady, mFifo.size() < INJ_DEPTH);
      check("cyc_trace_count", traceCount, mTrace.size());
      check("cyc_trace_overflow", traceOverflow, mOverflow);
      check("cyc_trace_rd_data", traceRdData, mRdData);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle();
    nextCycle();
    reset = 1'b1;
    mode = 2'd0;
    step = 1'b0;
    injValid = 1'b0;
    traceRdEn = 1'b0;
  endtask

  // Reset, let the unavoidable first PASS commit happen, then pop it: HALT, empty trace.
  task automatic resetToHalt();
    resetCycle();
    nextCycle(); reset = 1'b0; mode = 2'd3;
    nextCycle(); traceRdEn = 1'b1;
    nextCycle(); traceRdEn = 1'b0;
  endtask

  initial begin
    logic [31:0] pcFirst, pcSecond;

    // Reset state
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("rst_inst_out", instOut, NOP);
    check("rst_stall", stall, 1'b1);
    check("rst_inj_ready", injReady, 1'b1);
    check("rst_trace_count", traceCount, 0);
    check("rst_overflow", traceOverflow, 1'b0);
    check("rst_rd_data", traceRdData, 0);

    // 17 PASS commits into a 16-deep trace
    nextCycle(); reset = 1'b0; mode = 2'd0;
    @(negedge clk);
    check("pass_inst_out", instOut, imemWord);
    check("pass_stall", stall, 1'b0);
    nextCycle();
    @(negedge clk);
    pcSecond = pcIn;
    for (int i = 3; i <= 17; i++) begin
      nextCycle();
      if (i == 17) mode = 2'd3;
    end
    nextCycle(); traceRdEn = 1'b1;
    @(negedge clk);
    check("ovf_count", traceCount, 16);
    check("ovf_flag", traceOverflow, 1'b1);
    nextCycle(); traceRdEn = 1'b0;
    @(negedge clk);
    check("ovf_oldest_pc", traceRdData[63:32], pcSecond);
    check("ovf_count_after_pop", traceCount, 15);

    // Commit plus read with a full trace
    resetCycle();
    nextCycle(); reset = 1'b0; mode = 2'd0;
    @(negedge clk);
    pcFirst = pcIn;
    for (int i = 2; i <= 16; i++) nextCycle();
    nextCycle(); mode = 2'd3; traceRdEn = 1'b1;
    nextCycle(); traceRdEn = 1'b0;
    @(negedge clk);
    check("full_rdwr_count", traceCount, 16);
    check("full_rdwr_no_ovf", traceOverflow, 1'b0);
    check("full_rdwr_oldest_pc", traceRdData[63:32], pcFirst);

    // INJECT: three back-to-back pushes
    resetToHalt();
    mode = 2'd1;
    nextCycle(); injValid = 1'b1; injWord = 32'h804d0037;
    @(negedge clk);
    check("inj_empty_stall", stall, 1'b1);
    check("inj_empty_nop", instOut, NOP);
    nextCycle(); injWord = 32'h805d00e1;
    @(negedge clk);
    check("inj_issue0", instOut, 32'h804d0037);
    check("inj_issue0_stall", stall, 1'b0);
    nextCycle(); injWord = 32'h802d0400;
    @(negedge clk);
    check("inj_issue1", instOut, 32'h805d00e1);
    nextCycle(); injValid = 1'b0;
    @(negedge clk);
    check("inj_issue2", instOut, 32'h802d0400);
    check("inj_issue2_stall", stall, 1'b0);
    nextCycle();
    @(negedge clk);
    check("inj_done_stall", stall, 1'b1);
    check("inj_trace_count", traceCount, 3);

    // Fill the FIFO while halted, then drain in INJECT
    nextCycle(); mode = 2'd3;
    for (int i = 0; i < INJ_DEPTH; i++) begin
      nextCycle(); injValid = 1'b1; injWord = 32'hC000_0000 + i;
    end
    nextCycle(); injWord = 32'hDEAD_BEEF;
    @(negedge clk);
    check("fifo_full_ready", injReady, 1'b0);
    nextCycle(); injValid = 1'b0; mode = 2'd1;
    @(negedge clk);
    check("fifo_full_ready_hold", injReady, 1'b0);
    for (int i = 0; i < INJ_DEPTH; i++) begin
      nextCycle();
      @(negedge clk);
      check($sformatf("drain_%0d", i), instOut, 32'hC000_0000 + i);
    end
    nextCycle();
    @(negedge clk);
    check("drain_empty_stall", stall, 1'b1);

    // STEP mode
    nextCycle(); mode = 2'd3;
    nextCycle(); injValid = 1'b1; injWord = 32'h50240000;
    nextCycle(); injWord = 32'h50250004;
    nextCycle(); injValid = 1'b0; mode = 2'd2;
    nextCycle(); step = 1'b1;
    @(negedge clk);
    check("step_idle_stall", stall, 1'b1);
    nextCycle();
    @(negedge clk);
    check("step1_word", instOut, 32'h50240000);
    check("step1_stall", stall, 1'b0);
    nextCycle(); step = 1'b0;
    @(negedge clk);
    check("step_back_idle", stall, 1'b1);
    nextCycle(); step = 1'b1;
    @(negedge clk);
    check("step_in_arm_ignored", stall, 1'b1);
    check("step_in_arm_nop", instOut, NOP);
    nextCycle(); step = 1'b0;
    @(negedge clk);
    check("step2_word", instOut, 32'h50250004);
    nextCycle(); step = 1'b1;
    nextCycle(); step = 1'b0;
    @(negedge clk);
    check("step3_nop", instOut, NOP);
    check("step3_stall", stall, 1'b1);
    nextCycle();
    @(negedge clk);
    check("step3_no_trace", traceCount, 13);

    // Reset while armed with three FIFO entries
    for (int i = 0; i < 3; i++) begin
      nextCycle(); injValid = 1'b1; injWord = 32'hE000_0000 + i;
    end
    nextCycle(); injValid = 1'b0; step = 1'b1;
    nextCycle(); step = 1'b0; reset = 1'b1; injValid = 1'b1; injWord = 32'hEEEE_EEEE;
    @(negedge clk);
    check("rst_arm_nop", instOut, NOP);
    check("rst_arm_stall", stall, 1'b1);
    nextCycle(); reset = 1'b0; injValid = 1'b0; mode = 2'd1;
    @(negedge clk);
    check("post_rst_pass", instOut, imemWord);
    check("post_rst_stall", stall, 1'b0);
    check("post_rst_trace", traceCount, 0);
    check("post_rst_ready", injReady, 1'b1);
    nextCycle();
    @(negedge clk);
    check("post_rst_fifo_empty", stall, 1'b1);
    check("post_rst_fifo_nop", instOut, NOP);
    nextCycle(); mode = 2'd3;
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, limit 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/inst_inject_trace.md
INST_INJECT_TRACE -- requirements
Module: inst_inject_trace

Interface
REQ-001 Param DBITS, 32, datapath/PC width.
REQ-002 Param INST_BIT_WIDTH, 32, instruction word width.
REQ-003 Param INJ_DEPTH, 8, injection FIFO entries (power of 2, >=2).
REQ-004 Param TRACE_DEPTH, 16, trace buffer entries (power of 2, >=2).
REQ-005 Param NOP_WORD, 32'h80000000, word issued when no instruction is available.
REQ-006 Port clk  in  1  single clock, all state on rising edge.
REQ-007 Port reset  in  1  synchronous, active-high reset.
REQ-008 Port mode  in  2  0=PASS (IMEM), 1=INJECT, 2=STEP, 3=HALT.
REQ-009 Port step  in  1  single-step request, STEP mode only.
REQ-010 Port inj_valid / inj_word / inj_ready  in 1 / in INST_BIT_WIDTH / out 1  injection push handshake.
REQ-011 Port imem_word  in  INST_BIT_WIDTH  word from instruction memory.
REQ-012 Port inst_out  out  INST_BIT_WIDTH  word driven to the decoder.
REQ-013 Port stall  out  1  1 = processor holds PC and suppresses reg/mem writes this cycle.
REQ-014 Port pc_in / wrt_en / wrt_val  in DBITS / in 1 / in DBITS  committed-instruction PC, reg write enable, write value.
REQ-015 Port trace_rd_en  in  1  pop oldest trace entry.
REQ-016 Port trace_rd_data  out  2*DBITS+1  registered {wrt_en, pc_in, wrt_val} of popped entry.
REQ-017 Port trace_count / trace_overflow  out log2(TRACE_DEPTH)+1 / out 1  occupancy; sticky overwrite flag.

Function
REQ-018 State machine S_PASS, S_INJ, S_STEP_IDLE, S_STEP_ARM, S_HALT; next state from mode each cycle; STEP entry goes to S_STEP_IDLE.
REQ-019 S_PASS: inst_out = imem_word, stall = 0, every cycle is a commit.
REQ-020 S_INJ: FIFO non-empty -> inst_out = head, stall = 0, pop same cycle (commit); empty -> inst_out = NOP_WORD, stall = 1.
REQ-021 S_STEP_IDLE: inst_out = NOP_WORD, stall = 1; step=1 -> S_STEP_ARM.
REQ-022 S_STEP_ARM: exactly one cycle; FIFO non-empty -> commit head as S_INJ; empty -> NOP, stall = 1, no commit; then S_STEP_IDLE.
REQ-023 step ignored in S_STEP_ARM and outside STEP mode; step pulses are not queued.
REQ-024 S_HALT: inst_out = NOP_WORD, stall = 1, FIFO and trace retained.
REQ-025 Mode change mid-operation keeps FIFO and trace contents; takes effect next cycle.
REQ-026 inj_ready = FIFO not full; push iff inj_valid & inj_ready; push+pop in same cycle legal at any non-full occupancy.
REQ-027 No bypass: a word pushed into an empty FIFO is issuable next cycle, not same cycle.
REQ-028 Every commit cycle writes {wrt_en, pc_in, wrt_val} into the trace buffer (circular, TRACE_DEPTH).
REQ-029 Trace full + commit -> oldest entry overwritten, read pointer advances, trace_overflow set (sticky until reset).
REQ-030 trace_rd_en with count>0 -> trace_rd_data updated next edge with oldest entry; count>0 with no commit decrements count.
REQ-031 trace_rd_en with count=0 -> no pointer change, trace_rd_data holds.
REQ-032 Simultaneous commit and trace_rd_en: read returns oldest first, then write; count unchanged; if full, no overflow flagged.
REQ-033 FIFO and trace pointers wrap modulo depth; count saturates at depth.

Reset
REQ-034 reset=1 at edge: state S_PASS, FIFO empty (inj_ready=1), trace empty, trace_count=0, trace_overflow=0, trace_rd_data=0.
REQ-035 During a reset cycle, inst_out = NOP_WORD, stall = 1, no push, no commit; reset overrides all other inputs including mid-step.

Verification
REQ-036 INJECT, push 804d0037, 805d00e1, 802d0400 back-to-back -> issued on cycles 2,3,4 after first push; stall=0 only those cycles; trace_count=3.
REQ-037 INJECT, push INJ_DEPTH=8 words with mode=HALT -> inj_ready=0 after 8th; 9th inj_valid ignored; switch to INJECT -> 8 words issued in order.
REQ-038 STEP, FIFO holds 50240000, 50250004; step pulses 2 cycles apart -> one issue per pulse; step while in S_STEP_ARM ignored; third step -> NOP, stall=1, no trace entry.
REQ-039 PASS for 17 commits with TRACE_DEPTH=16 -> trace_overflow=1, count=16, first pop returns 2nd commit's pc_in.
REQ-040 Commit plus trace_rd_en with count=16 -> count stays 16, overflow unchanged, oldest returned.
REQ-041 reset asserted in S_STEP_ARM with 3 FIFO entries -> next cycle S_PASS, FIFO empty, trace empty, inst_out=imem_word.
